hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage in-order RV32 core.
- Drives the stall/flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the EX-stage forwarding mux selects.
- Handles load-use bubbles, taken-branch flushes and multi-cycle data-memory waits with a timeout.
- Sequences the post-reset pipeline flush.

---
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side status in, stall/flush/forward controls out.
// The pipeline drives through the master modport; the controller uses the slave modport.
interface hazard_ctrl_if;
    logic [4:0] rs1d, rs2d;
    logic [4:0] rs1e, rs2e;
    logic [4:0] rde;
    logic [1:0] rsltSrce;
    logic       pcSrce;
    logic       regWrtm;
    logic [4:0] rdm;
    logic       regWrtw;
    logic [4:0] rdw;
    logic       memReqm;
    logic       memRdym;
    logic       stallf, stalld, stalle, stallm;
    logic       flushd, flushe, flushw;
    logic [1:0] fwdAe, fwdBe;
    logic       memErr;

    modport master (
        output rs1d, rs2d, rs1e, rs2e, rde, rsltSrce, pcSrce,
               regWrtm, rdm, regWrtw, rdw, memReqm, memRdym,
        input  stallf, stalld, stalle, stallm, flushd, flushe, flushw,
               fwdAe, fwdBe, memErr
    );

    modport slave (
        input  rs1d, rs2d, rs1e, rs2e, rde, rsltSrce, pcSrce,
               regWrtm, rdm, regWrtw, rdw, memReqm, memRdym,
        output stallf, stalld, stalle, stallm, flushd, flushe, flushw,
               fwdAe, fwdBe, memErr
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding controller for the 5-stage RV32 pipeline.
// Handles post-reset flush, load-use bubbles, taken-branch flushes and
// data-memory waits with a timeout into a sticky error state.
// Optional macro PERF_CNT_EN adds stallCnt/flushCnt performance counters.
module hazard_ctrl #(
    parameter int RST_CYC     = 2,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rstn,
    hazard_ctrl_if.slave hz
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt
`endif
);

    typedef enum logic [1:0] {INIT, RUN, MWAIT, ERR} state_e;

    localparam int CMAX = (RST_CYC > MEM_TIMEOUT) ? RST_CYC : MEM_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active;
    logic          freeze;
    logic          lw;

    // Memory freeze only applies while the pipeline is actually running.
    assign active = (state_q == RUN) || (state_q == MWAIT);
    assign freeze = active && hz.memReqm && !hz.memRdym;

    // Load in EX feeding the instruction in ID; x0 never creates a dependency.
    assign lw = (hz.rsltSrce == 2'b01) && (hz.rde != 5'd0) &&
                ((hz.rde == hz.rs1d) || (hz.rde == hz.rs2d));

    // State and counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: init countdown, memory-wait tracking and timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (freeze) begin
                    state_d = MWAIT;
                    cnt_d   = CW'(1);
                end
            end
            MWAIT: begin
                if (!freeze) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d = ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    // Stall/flush decode: freeze beats branch, branch beats load-use.
    always_comb begin
        hz.stallf = 1'b0;
        hz.stalld = 1'b0;
        hz.stalle = 1'b0;
        hz.stallm = 1'b0;
        hz.flushd = 1'b0;
        hz.flushe = 1'b0;
        hz.flushw = 1'b0;
        if (!active) begin
            // INIT and ERR hold the front end and keep bubbles flowing.
            hz.stallf = 1'b1;
            hz.flushd = 1'b1;
            hz.flushe = 1'b1;
            hz.flushw = 1'b1;
        end else if (freeze) begin
            hz.stallf = 1'b1;
            hz.stalld = 1'b1;
            hz.stalle = 1'b1;
            hz.stallm = 1'b1;
            hz.flushw = 1'b1;
        end else if (hz.pcSrce) begin
            // ID holds a wrong-path instruction, so a load-use stall is moot.
            hz.flushd = 1'b1;
            hz.flushe = 1'b1;
        end else if (lw) begin
            hz.stallf = 1'b1;
            hz.stalld = 1'b1;
            hz.flushe = 1'b1;
        end
    end

    // EX operand forwarding, MEM result preferred over WB; quiet during init.
    always_comb begin
        hz.fwdAe = 2'b00;
        hz.fwdBe = 2'b00;
        if (state_q != INIT) begin
            if (hz.regWrtm && hz.rdm != 5'd0 && hz.rdm == hz.rs1e)
                hz.fwdAe = 2'b10;
            else if (hz.regWrtw && hz.rdw != 5'd0 && hz.rdw == hz.rs1e)
                hz.fwdAe = 2'b01;
            if (hz.regWrtm && hz.rdm != 5'd0 && hz.rdm == hz.rs2e)
                hz.fwdBe = 2'b10;
            else if (hz.regWrtw && hz.rdw != 5'd0 && hz.rdw == hz.rs2e)
                hz.fwdBe = 2'b01;
        end
    end

    // The error flag is the ERR state itself, so it is sticky until reset.
    assign hz.memErr = (state_q == ERR);

`ifdef PERF_CNT_EN
    logic [31:0] stallCnt_q, flushCnt_q;

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (active && hz.stallf)
                stallCnt_q <= stallCnt_q + 32'd1;
            if ((state_q == RUN) && hz.pcSrce && hz.flushd)
                flushCnt_q <= flushCnt_q + 32'd1;
        end
    end

    assign stallCnt = stallCnt_q;
    assign flushCnt = flushCnt_q;
`endif

endmodule
